// File: rtl/mips_multicycle_control_pkg.sv
// Shared constants for the multicycle MIPS controller: opcodes, functs,
// ALU control codes, FSM state encoding and datapath mux-select encodings.
package mips_defines;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_JR  = 6'd8;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_XOR = 6'd38;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_XOR = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_SLL = 4'd8,
    ALU_SRL = 4'd9
  } alu_ctl_e;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_FETCH_WAIT = 4'd1,
    S_DECODE     = 4'd2,
    S_EXEC_R     = 4'd3,
    S_RWB        = 4'd4,
    S_EXEC_I     = 4'd5,
    S_IWB        = 4'd6,
    S_MEMADR     = 4'd7,
    S_MEMREAD    = 4'd8,
    S_MEMWB      = 4'd9,
    S_MEMWRITE   = 4'd10,
    S_BRANCH     = 4'd11,
    S_JUMP       = 4'd12,
    S_JR         = 4'd13,
    S_ERROR      = 4'd15
  } state_e;

  // Which ALU operation family the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_ITYPE = 2'd3
  } alu_cls_e;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_A     = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_B       = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_SEXT    = 3'd2;
  localparam logic [2:0] SRCB_ZEXT    = 3'd3;
  localparam logic [2:0] SRCB_SEXT_SH = 3'd4;
  localparam logic [2:0] SRCB_LUI     = 3'd5;

  // Dispatch target out of DECODE.
  function automatic state_e decode_dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_e s;
    case (op)
      OP_RTYPE:                                  s = (fn == FN_JR) ? S_JR : S_EXEC_R;
      OP_LW, OP_SW:                              s = S_MEMADR;
      OP_BEQ, OP_BNE:                            s = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_LUI: s = S_EXEC_I;
      OP_J, OP_JAL:                              s = S_JUMP;
      default:                                   s = S_ERROR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU control decode from the state's operation class plus
// the instruction opcode/funct; flags functs/opcodes with no ALU mapping.
module mips_alu_decoder
  import mips_defines::*;
(
  input  alu_cls_e    i_cls,
  input  logic [5:0]  i_opcode,
  input  logic [5:0]  i_funct,
  output alu_ctl_e    o_alu_ctl,
  output logic        o_illegal
);

  always_comb begin
    o_alu_ctl = ALU_ADD;
    o_illegal = 1'b0;
    case (i_cls)
      CLS_SUB: o_alu_ctl = ALU_SUB;
      CLS_RTYPE: begin
        case (i_funct)
          FN_SLL:  o_alu_ctl = ALU_SLL;
          FN_SRL:  o_alu_ctl = ALU_SRL;
          FN_ADD:  o_alu_ctl = ALU_ADD;
          FN_SUB:  o_alu_ctl = ALU_SUB;
          FN_AND:  o_alu_ctl = ALU_AND;
          FN_OR:   o_alu_ctl = ALU_OR;
          FN_XOR:  o_alu_ctl = ALU_XOR;
          FN_NOR:  o_alu_ctl = ALU_NOR;
          FN_SLT:  o_alu_ctl = ALU_SLT;
          default: o_illegal = 1'b1;
        endcase
      end
      CLS_ITYPE: begin
        case (i_opcode)
          OP_ADDI: o_alu_ctl = ALU_ADD;
          OP_SLTI: o_alu_ctl = ALU_SLT;
          OP_ANDI: o_alu_ctl = ALU_AND;
          OP_ORI:  o_alu_ctl = ALU_OR;
          OP_LUI:  o_alu_ctl = ALU_ADD;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore sequencer for the multicycle MIPS datapath, with single-step mode.
// state | meaning
// FETCH 0 | memory read at PC; waits for step in step mode
// FETCH_WAIT 1 | load IR, PC <= PC+4
// DECODE 2 | ALUOut <= branch target, dispatch on opcode
// EXEC_R 3 | R-type ALU op
// RWB 4 | write rd
// EXEC_I 5 | immediate ALU op
// IWB 6 | write rt
// MEMADR 7 | compute load/store address
// MEMREAD 8 | memory read at ALUOut
// MEMWB 9 | write loaded data to rt
// MEMWRITE 10 | memory write at ALUOut
// BRANCH 11 | compare, conditional PC load
// JUMP 12 | PC <= jump target (jal also links $31)
// JR 13 | PC <= rs
// ERROR 15 | illegal instruction, held until reset
module mips_multicycle_control
  import mips_defines::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               step_mode,
  input  logic               step,
  output logic               pc_wr,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_wr_ena,
  output logic               ir_wr,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic [3:0]         alu_ctl,
  output logic               instr_done,
  output logic               error,
  output logic [STATE_W-1:0] state
);

  state_e   r_state;
  state_e   w_next;
  state_e   w_cur;
  alu_cls_e w_cls;
  alu_ctl_e w_alu_ctl;
  logic     w_illegal;

  always_ff @(posedge clk) begin
    if (!rstb) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Outputs decode from FETCH while reset is low so nothing writes in the reset cycle.
  always_comb begin
    w_cur = r_state;
    if (!rstb) w_cur = S_FETCH;
  end

  always_comb begin
    w_cls = CLS_ADD;
    case (w_cur)
      S_EXEC_R: w_cls = CLS_RTYPE;
      S_EXEC_I: w_cls = CLS_ITYPE;
      S_BRANCH: w_cls = CLS_SUB;
      default:  w_cls = CLS_ADD;
    endcase
  end

  mips_alu_decoder u_alu_dec (
    .i_cls     (w_cls),
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_alu_ctl (w_alu_ctl),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:      if (!step_mode || step) w_next = S_FETCH_WAIT;
      S_FETCH_WAIT: w_next = S_DECODE;
      S_DECODE:     w_next = decode_dispatch(opcode, funct);
      S_EXEC_R:     w_next = w_illegal ? S_ERROR : S_RWB;
      S_EXEC_I:     w_next = S_IWB;
      S_MEMADR:     w_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:    w_next = S_MEMWB;
      S_RWB, S_IWB, S_MEMWB, S_MEMWRITE,
      S_BRANCH, S_JUMP, S_JR: w_next = S_FETCH;
      S_ERROR:      w_next = S_ERROR;
      default:      w_next = S_ERROR;
    endcase
  end

  always_comb begin
    pc_wr      = 1'b0;
    pc_src     = PCSRC_ALU;
    iord       = 1'b0;
    mem_wr_ena = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = REGDST_RT;
    mem_to_reg = M2R_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_B;
    instr_done = 1'b0;
    error      = 1'b0;
    case (w_cur)
      S_FETCH_WAIT: begin
        ir_wr     = 1'b1;
        pc_wr     = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_SEXT_SH;
      S_EXEC_R: begin
        alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? SRCA_SHAMT : SRCA_A;
        alu_src_b = SRCB_B;
      end
      S_RWB: begin
        reg_wr     = 1'b1;
        reg_dst    = REGDST_RD;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_A;
        case (opcode)
          OP_ANDI, OP_ORI: alu_src_b = SRCB_ZEXT;
          OP_LUI:          alu_src_b = SRCB_LUI;
          default:         alu_src_b = SRCB_SEXT;
        endcase
      end
      S_IWB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_SEXT;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        reg_wr     = 1'b1;
        mem_to_reg = M2R_MDR;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        mem_wr_ena = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_B;
        pc_src     = PCSRC_ALUOUT;
        pc_wr      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          reg_wr     = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        pc_src     = PCSRC_RS;
        pc_wr      = 1'b1;
        instr_done = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctl = w_alu_ctl;
  assign state   = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS controller: per-instruction state
// traces, output decodes, reset behaviour, error latch and single-step mode.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rstb;
  logic [5:0] opcode, funct;
  logic       zero, step_mode, step;
  logic       pc_wr, iord, mem_wr_ena, ir_wr, reg_wr, instr_done, error;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_a;
  logic [2:0] alu_src_b;
  logic [3:0] alu_ctl, state;

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rstb(rstb), .opcode(opcode), .funct(funct), .zero(zero),
    .step_mode(step_mode), .step(step), .pc_wr(pc_wr), .pc_src(pc_src),
    .iord(iord), .mem_wr_ena(mem_wr_ena), .ir_wr(ir_wr), .reg_wr(reg_wr),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctl(alu_ctl), .instr_done(instr_done),
    .error(error), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       iord, mem_wr, ir_wr, reg_wr;
    logic [1:0] reg_dst, m2r, asa;
    logic [2:0] asb;
    logic [3:0] alu;
    logic       done;
  } snap_t;

  snap_t tr [0:31];
  int    n_cyc;
  int    n_err = 0;
  int    n_checks = 0;
  int    done_cnt = 0;
  int    base;

  always @(negedge clk) if (instr_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH (step_mode=0) until back in FETCH, recording every cycle.
  task automatic exec(input logic [5:0] op, input logic [5:0] fn, input logic z);
    opcode = op; funct = fn; zero = z;
    #1;
    n_cyc = 0;
    do begin
      tr[n_cyc] = {state, pc_wr, pc_src, iord, mem_wr_ena, ir_wr, reg_wr,
                   reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_ctl, instr_done};
      n_cyc++;
      cyc();
    end while (state !== 4'd0 && n_cyc < 20);
    check("back_in_fetch", state, 0);
  endtask

  function automatic int sum_regwr();
    int s = 0;
    for (int i = 0; i < n_cyc; i++) s += int'(tr[i].reg_wr);
    return s;
  endfunction

  function automatic int sum_memwr();
    int s = 0;
    for (int i = 0; i < n_cyc; i++) s += int'(tr[i].mem_wr);
    return s;
  endfunction

  function automatic int sum_done();
    int s = 0;
    for (int i = 0; i < n_cyc; i++) s += int'(tr[i].done);
    return s;
  endfunction

  initial begin
    rstb = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; step_mode = 1'b0; step = 1'b0;
    cyc(); cyc();
    check("rst_state", state, 0);
    check("rst_pc_wr", pc_wr, 0);
    check("rst_reg_wr", reg_wr, 0);
    check("rst_mem_wr", mem_wr_ena, 0);
    check("rst_ir_wr", ir_wr, 0);
    check("rst_error", error, 0);
    check("rst_alu_ctl", alu_ctl, 2);
    rstb = 1'b1;

    // R-type add
    exec(6'd0, 6'd32, 1'b0);
    check("add_len", n_cyc, 5);
    check("add_s1", tr[1].st, 1);
    check("add_fw_irwr", tr[1].ir_wr, 1);
    check("add_fw_pcwr", tr[1].pc_wr, 1);
    check("add_fw_asb", tr[1].asb, 1);
    check("add_dec_asb", tr[2].asb, 4);
    check("add_s3", tr[3].st, 3);
    check("add_ex_asa", tr[3].asa, 1);
    check("add_ex_alu", tr[3].alu, 2);
    check("add_s4", tr[4].st, 4);
    check("add_rwb_regwr", tr[4].reg_wr, 1);
    check("add_rwb_dst", tr[4].reg_dst, 1);
    check("add_regwr_cnt", sum_regwr(), 1);
    check("add_done_cnt", sum_done(), 1);

    // sll uses shamt on port A
    exec(6'd0, 6'd0, 1'b0);
    check("sll_asa", tr[3].asa, 2);
    check("sll_alu", tr[3].alu, 8);
    exec(6'd0, 6'd42, 1'b0);
    check("slt_alu", tr[3].alu, 7);

    // lw then sw
    exec(6'd35, 6'd0, 1'b0);
    check("lw_len", n_cyc, 6);
    check("lw_s3", tr[3].st, 7);
    check("lw_adr_asb", tr[3].asb, 2);
    check("lw_s4", tr[4].st, 8);
    check("lw_rd_iord", tr[4].iord, 1);
    check("lw_s5", tr[5].st, 9);
    check("lw_wb_m2r", tr[5].m2r, 1);
    check("lw_wb_regwr", tr[5].reg_wr, 1);
    check("lw_done_cnt", sum_done(), 1);
    exec(6'd43, 6'd0, 1'b0);
    check("sw_len", n_cyc, 5);
    check("sw_s4", tr[4].st, 10);
    check("sw_iord", tr[4].iord, 1);
    check("sw_memwr_cnt", sum_memwr(), 1);
    check("sw_regwr_cnt", sum_regwr(), 0);

    // branches
    exec(6'd4, 6'd0, 1'b1);
    check("beq_len", n_cyc, 4);
    check("beq_s3", tr[3].st, 11);
    check("beq_z1_pcwr", tr[3].pc_wr, 1);
    check("beq_pcsrc", tr[3].pc_src, 1);
    check("beq_alu", tr[3].alu, 6);
    exec(6'd4, 6'd0, 1'b0);
    check("beq_z0_pcwr", tr[3].pc_wr, 0);
    exec(6'd5, 6'd0, 1'b1);
    check("bne_z1_pcwr", tr[3].pc_wr, 0);
    exec(6'd5, 6'd0, 1'b0);
    check("bne_z0_pcwr", tr[3].pc_wr, 1);

    // jumps
    exec(6'd3, 6'd0, 1'b0);
    check("jal_len", n_cyc, 4);
    check("jal_s3", tr[3].st, 12);
    check("jal_pcwr", tr[3].pc_wr, 1);
    check("jal_pcsrc", tr[3].pc_src, 2);
    check("jal_regwr", tr[3].reg_wr, 1);
    check("jal_dst", tr[3].reg_dst, 2);
    check("jal_m2r", tr[3].m2r, 2);
    exec(6'd2, 6'd0, 1'b0);
    check("j_regwr", tr[3].reg_wr, 0);
    exec(6'd0, 6'd8, 1'b0);
    check("jr_len", n_cyc, 4);
    check("jr_s3", tr[3].st, 13);
    check("jr_pcsrc", tr[3].pc_src, 3);

    // I-type
    exec(6'd8, 6'd0, 1'b0);
    check("addi_len", n_cyc, 5);
    check("addi_s3", tr[3].st, 5);
    check("addi_asb", tr[3].asb, 2);
    check("addi_s4", tr[4].st, 6);
    check("addi_wb_dst", tr[4].reg_dst, 0);
    check("addi_wb_regwr", tr[4].reg_wr, 1);
    exec(6'd12, 6'd0, 1'b0);
    check("andi_asb", tr[3].asb, 3);
    check("andi_alu", tr[3].alu, 0);
    exec(6'd15, 6'd0, 1'b0);
    check("lui_asb", tr[3].asb, 5);
    exec(6'd10, 6'd0, 1'b0);
    check("slti_alu", tr[3].alu, 7);

    // reset asserted while in MEMWRITE
    opcode = 6'd43; funct = 6'd0;
    repeat (4) cyc();
    check("swr_state", state, 10);
    check("swr_memwr_pre", mem_wr_ena, 1);
    rstb = 1'b0; #1;
    check("swr_memwr_rst", mem_wr_ena, 0);
    check("swr_iord_rst", iord, 0);
    cyc(); cyc();
    check("swr_state_after", state, 0);
    rstb = 1'b1;

    // illegal opcode latches ERROR
    opcode = 6'd63;
    repeat (3) cyc();
    check("err_state", state, 15);
    check("err_flag", error, 1);
    repeat (100) cyc();
    check("err_held_state", state, 15);
    check("err_held_flag", error, 1);
    check("err_pcwr", pc_wr, 0);
    check("err_regwr", reg_wr, 0);
    rstb = 1'b0; #1;
    check("err_rst_gated", error, 0);
    cyc(); cyc();
    check("err_rst_state", state, 0);
    rstb = 1'b1;

    // illegal funct goes through EXEC_R to ERROR
    opcode = 6'd0; funct = 6'd1;
    repeat (4) cyc();
    check("badfn_state", state, 15);
    rstb = 1'b0; cyc(); cyc(); rstb = 1'b1;
    funct = 6'd0;

    // single-step mode
    step_mode = 1'b1; opcode = 6'd8;
    repeat (50) cyc();
    check("step_hold_state", state, 0);
    check("step_hold_irwr", ir_wr, 0);
    base = done_cnt;
    step = 1'b1; cyc(); step = 1'b0;
    check("step_fw", state, 1);
    cyc();
    check("step_dec", state, 2);
    step = 1'b1; cyc(); step = 1'b0;
    check("step_mid_exec", state, 5);
    cyc();
    check("step_iwb", state, 6);
    cyc(); cyc(); cyc();
    check("step_back_hold", state, 0);
    check("step_done_cnt", done_cnt - base, 1);

    // step coinciding with reset is ignored
    rstb = 1'b0; step = 1'b1; cyc(); step = 1'b0; rstb = 1'b1;
    check("step_rst_state", state, 0);
    cyc();
    check("step_rst_hold", state, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
